// File: rtl/count_chk_pkg.sv
// count_chk_pkg: shared FSM states, direction-mode encodings and counter width
package count_chk_pkg;
  localparam int CNT_W = 4;
  localparam logic [1:0] MODE_AUTO = 2'b00;
  localparam logic [1:0] MODE_UP   = 2'b01;
  localparam logic [1:0] MODE_DOWN = 2'b10;
  typedef enum logic [1:0] {ST_UNSYNC, ST_SYNC, ST_LOCKED} state_t;
endpackage

// File: rtl/step_classifier.sv
// step_classifier: classifies a mod-16 counter step as up, down and wrap
module step_classifier
  import count_chk_pkg::*;
(
  input  logic [CNT_W-1:0] prev,
  input  logic [CNT_W-1:0] count,
  output logic             is_up,
  output logic             is_down,
  output logic             is_wrap_up,
  output logic             is_wrap_down
);
  assign is_up        = count == CNT_W'(prev + 1'b1);
  assign is_down      = count == CNT_W'(prev - 1'b1);
  assign is_wrap_up   = is_up && prev == '1;
  assign is_wrap_down = is_down && prev == '0;
endmodule

// File: rtl/count_seq_checker.sv
// count_seq_checker: locks onto an up/down mod-16 count sequence and flags breaks
module count_seq_checker
  import count_chk_pkg::*;
#(
  parameter int LOCK_LEN = 3
) (
  input  logic             CLOCK,
  input  logic             CLEAR,
  input  logic [CNT_W-1:0] COUNT,
  input  logic             SAMPLE,
  input  logic [1:0]       DIR_MODE,
  output logic             LOCKED,
  output logic             DIR,
  output logic             ERROR,
  output logic             WRAP,
  output logic [7:0]       ERR_COUNT
);
  state_t           state;
  logic [CNT_W-1:0] prev;
  logic [3:0]       run;
  logic [3:0]       run_nx;
  logic [1:0]       mode_q;
  logic             cand_ok;
  logic             cand;
  logic             up;
  logic             dn;
  logic             wu;
  logic             wd;
  logic             forced;
  logic             want;
  logic             match;
  step_classifier u_cls (
    .prev        (prev),
    .count       (COUNT),
    .is_up       (up),
    .is_down     (dn),
    .is_wrap_up  (wu),
    .is_wrap_down(wd)
  );
  always_comb begin
    forced = DIR_MODE == MODE_UP || DIR_MODE == MODE_DOWN;
    want   = forced ? DIR_MODE == MODE_UP : cand;
    match  = (up || dn) && ((forced || cand_ok) ? up == want : 1'b1);
    run_nx = run + 1'b1;
  end
  always_ff @(posedge CLOCK) begin
    if (CLEAR) begin
      state     <= ST_UNSYNC;
      prev      <= '0;
      run       <= '0;
      cand_ok   <= 1'b0;
      cand      <= 1'b0;
      mode_q    <= DIR_MODE;
      LOCKED    <= 1'b0;
      DIR       <= 1'b0;
      ERROR     <= 1'b0;
      WRAP      <= 1'b0;
      ERR_COUNT <= '0;
    end else begin
      ERROR <= 1'b0;
      WRAP  <= 1'b0;
      if (DIR_MODE != mode_q) begin
        mode_q <= DIR_MODE;
        state  <= ST_UNSYNC;
        LOCKED <= 1'b0;
      end else if (SAMPLE) begin
        prev <= COUNT;
        case (state)
          ST_UNSYNC: begin
            run     <= '0;
            cand_ok <= 1'b0;
            state   <= ST_SYNC;
          end
          ST_SYNC: begin
            if (match) begin
              cand    <= up;
              cand_ok <= 1'b1;
              run     <= run_nx;
              if (run_nx == 4'(LOCK_LEN)) begin
                state  <= ST_LOCKED;
                LOCKED <= 1'b1;
                DIR    <= up;
              end
            end else begin
              run     <= '0;
              cand_ok <= 1'b0;
            end
          end
          ST_LOCKED: begin
            if ((up || dn) && up == DIR) begin
              WRAP <= up ? wu : wd;
            end else begin
              ERROR     <= 1'b1;
              ERR_COUNT <= ERR_COUNT + {7'd0, ~&ERR_COUNT};
              LOCKED    <= 1'b0;
              state     <= ST_SYNC;
              run       <= '0;
              cand_ok   <= 1'b0;
            end
          end
          default: state <= ST_UNSYNC;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_count_seq_checker.sv
// tb_count_seq_checker: directed scoreboard bench for count_seq_checker
module tb_count_seq_checker;
  logic       CLOCK = 1'b0;
  logic       CLEAR;
  logic       SAMPLE;
  logic [3:0] COUNT;
  logic [1:0] DIR_MODE;
  logic       LOCKED;
  logic       DIR;
  logic       ERROR;
  logic       WRAP;
  logic [7:0] ERR_COUNT;
  typedef struct {
    int          id;
    logic [11:0] v;
  } exp_t;
  exp_t        q[$];
  exp_t        ex;
  logic [11:0] got;
  int          checks = 0;
  int          errors = 0;
  int          sid = 0;
  int          c;
  count_seq_checker #(.LOCK_LEN(3)) dut (
    .CLOCK    (CLOCK),
    .CLEAR    (CLEAR),
    .COUNT    (COUNT),
    .SAMPLE   (SAMPLE),
    .DIR_MODE (DIR_MODE),
    .LOCKED   (LOCKED),
    .DIR      (DIR),
    .ERROR    (ERROR),
    .WRAP     (WRAP),
    .ERR_COUNT(ERR_COUNT)
  );
  always #10 CLOCK = ~CLOCK;
  task automatic step(input logic clr, input logic smp, input logic [1:0] md, input int cnt,
                      input logic l, input logic d, input logic e, input logic w, input int ec);
    CLEAR    = clr;
    SAMPLE   = smp;
    DIR_MODE = md;
    COUNT    = 4'(cnt);
    q.push_back('{sid, {l, d, e, w, 8'(ec)}});
    sid++;
    @(negedge CLOCK);
  endtask
  always @(posedge CLOCK) begin
    #1;
    if (q.size() > 0) begin
      ex  = q.pop_front();
      got = {LOCKED, DIR, ERROR, WRAP, ERR_COUNT};
      checks++;
      if (got !== ex.v) begin
        errors++;
        $display("FAIL step%0d got L=%b D=%b E=%b W=%b EC=%0d expected L=%b D=%b E=%b W=%b EC=%0d",
                 ex.id, got[11], got[10], got[9], got[8], got[7:0],
                 ex.v[11], ex.v[10], ex.v[9], ex.v[8], ex.v[7:0]);
      end
    end
  end
  initial begin
    step(1, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    step(1, 1, 2'b00, 5, 0, 0, 0, 0, 0);
    // auto up through a wrap
    for (int k = 0; k < 18; k++) step(0, 1, 2'b00, k, k >= 3, k >= 3, 0, k == 16, 0);
    // auto down through a wrap
    step(1, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 17; k++) step(0, 1, 2'b00, 15 - k, k >= 3, 0, 0, k == 16, 0);
    step(0, 0, 2'b00, 7, 1, 0, 0, 0, 0);
    step(0, 0, 2'b00, 3, 1, 0, 0, 0, 0);
    step(0, 1, 2'b00, 14, 1, 0, 0, 0, 0);
    // lock up, skip a value, relock; DIR holds while unlocked
    step(1, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    step(0, 1, 2'b00, 14, 0, 0, 0, 0, 0);
    step(0, 1, 2'b00, 15, 0, 0, 0, 0, 0);
    step(0, 1, 2'b00, 0, 0, 0, 0, 0, 0);
    step(0, 1, 2'b00, 1, 1, 1, 0, 0, 0);
    step(0, 1, 2'b00, 2, 1, 1, 0, 0, 0);
    step(0, 1, 2'b00, 3, 1, 1, 0, 0, 0);
    step(0, 1, 2'b00, 5, 0, 1, 1, 0, 1);
    step(0, 1, 2'b00, 6, 0, 1, 0, 0, 1);
    step(0, 1, 2'b00, 7, 0, 1, 0, 0, 1);
    step(0, 1, 2'b00, 8, 1, 1, 0, 0, 1);
    step(0, 1, 2'b01, 9, 0, 1, 0, 0, 1);
    // forced up mode never locks on a down sequence
    step(1, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    step(0, 0, 2'b01, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 20; k++) step(0, 1, 2'b01, 9 - k, 0, 0, 0, 0, 0);
    // forced down mode locks, wraps, then errors on an up step
    step(0, 1, 2'b10, 5, 0, 0, 0, 0, 0);
    step(0, 1, 2'b10, 4, 0, 0, 0, 0, 0);
    step(0, 1, 2'b10, 3, 0, 0, 0, 0, 0);
    step(0, 1, 2'b10, 2, 0, 0, 0, 0, 0);
    step(0, 1, 2'b10, 1, 1, 0, 0, 0, 0);
    step(0, 1, 2'b10, 0, 1, 0, 0, 0, 0);
    step(0, 1, 2'b10, 15, 1, 0, 0, 1, 0);
    step(0, 1, 2'b10, 0, 0, 0, 1, 0, 1);
    // clear coincident with a sample while locked
    step(1, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) step(0, 1, 2'b00, k, k >= 3, k >= 3, 0, 0, 0);
    step(1, 1, 2'b00, 5, 0, 0, 0, 0, 0);
    for (int k = 6; k < 10; k++) step(0, 1, 2'b00, k, k == 9, k == 9, 0, 0, 0);
    // repeated lock/break cycles saturate the error counter
    step(1, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) step(0, 1, 2'b00, k, k == 3, k == 3, 0, 0, 0);
    c = 3;
    for (int i = 1; i <= 300; i++) begin
      c += 2;
      step(0, 1, 2'b00, c, 0, 1, 1, 0, i < 255 ? i : 255);
      for (int j = 1; j <= 3; j++) begin
        c++;
        step(0, 1, 2'b00, c, j == 3, 1, 0, 0, i < 255 ? i : 255);
      end
    end
    step(0, 0, 2'b00, 0, 1, 1, 0, 0, 255);
    for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge CLOCK);
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain got %0d pending expected 0 pending", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
